ram_rw_ctrl: RTL and testbench

//  Self-test sequencer sitting directly upstream of the single-port block RAM inside ip_ram.
//  On a start pulse it writes a known pattern into every RAM word, then reads every word back.
//  It compares each returned word against the expected pattern and reports pass/fail.

---
 rtl/ram_rw_ctrl_pkg.sv | 24 ++
 rtl/ram_rw_ctrl_rd_lat_pipe.sv | 35 +++
 rtl/ram_rw_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ram_rw_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ram_rw_ctrl_pkg.sv
// ram_rw_ctrl_pkg
//   Shared definitions for the RAM self-test sequencer.
//   - state_e : sequencer state encoding (3-bit)
//   - pattern : expected data for address k (bitwise inverse of k)
//   Optional compare logic in the top is guarded by `RAM_RW_CHECK_EN.
package ram_rw_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Wide enough for any practical DATA_W; callers truncate to their width.
    localparam int PAT_W = 64;

    // Inverted address so that a dead, all-zero RAM cannot pass.
    function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] k);
        return ~k;
    endfunction

endpackage

// File: rtl/ram_rw_ctrl_rd_lat_pipe.sv
// rd_lat_pipe
//   STAGES-deep shift register that carries {valid, expected data} alongside
//   the RAM read path so the comparator sees the expectation in the same
//   cycle the read data returns.
//   Ports:
//     clk_i   in  1  clock, rising edge
//     rst_ni  in  1  asynchronous active-low reset, clears every stage
//     d_i     in  W  value pushed every cycle
//     q_o     out W  value pushed STAGES cycles earlier
module rd_lat_pipe #(
    parameter int W      = 9,
    parameter int STAGES = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [STAGES-1:0][W-1:0] stg_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stg_q <= '0;
        end else begin
            stg_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stg_q[i] <= stg_q[i-1];
            end
        end
    end

    assign q_o = stg_q[STAGES-1];

endmodule

// File: rtl/ram_rw_ctrl.sv
// ram_rw_ctrl
//   RAM bring-up self-test sequencer. A start pulse in IDLE writes
//   pattern(k) to addresses 0..DEPTH-1, reads them all back, waits RD_LAT
//   cycles for the last read to return, then pulses done.
//   Optional feature macro: RAM_RW_CHECK_EN enables the read-data comparator
//   (err / err_cnt); without it err and err_cnt are tied to 0 and the
//   sequencing is identical.
//   Ports:
//     sys_clk    in   1         clock, rising edge
//     sys_rst_n  in   1         asynchronous active-low reset
//     start      in   1         one-cycle pass request (ignored unless idle)
//     ram_en     out  1         RAM port enable
//     ram_we     out  1         RAM write enable
//     ram_addr   out  ADDR_W    RAM address
//     ram_wdata  out  DATA_W    RAM write data
//     ram_rdata  in   DATA_W    RAM read data, RD_LAT clocks after address
//     busy       out  1         first WRITE cycle through DONE cycle
//     done       out  1         one-cycle end-of-pass pulse
//     err        out  1         sticky mismatch flag, cleared on pass start
//     err_cnt    out  ADDR_W+1  saturating mismatch count
module ram_rw_ctrl
    import ram_rw_ctrl_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   err_cnt
);

    localparam int                DRN_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
    localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'(RD_LAT - 1);

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] k);
        return DATA_W'(pattern(PAT_W'(k)));
    endfunction

    state_e             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DRN_W-1:0]   drn_q;
    logic               en_q, we_q, busy_q, done_q;
    logic [DATA_W-1:0]  wdata_q;

    // Sequencer; every RAM-facing output is a register so the address,
    // enable and data for cycle k all change on the same edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            drn_q   <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_WRITE;
                        addr_q  <= '0;
                        en_q    <= 1'b1;
                        we_q    <= 1'b1;
                        wdata_q <= pat('0);
                        busy_q  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (addr_q == LAST) begin
                        state_q <= ST_READ;
                        addr_q  <= '0;
                        we_q    <= 1'b0;
                        wdata_q <= '0;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                        wdata_q <= pat(addr_q + 1'b1);
                    end
                end
                ST_READ: begin
                    if (addr_q == LAST) begin
                        state_q <= ST_DRAIN;
                        addr_q  <= '0;
                        en_q    <= 1'b0;
                        drn_q   <= '0;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Hold off done until the final read has been compared.
                    if (drn_q == DRN_LAST) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        drn_q   <= drn_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    addr_q  <= '0;
                    en_q    <= 1'b0;
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ram_en    = en_q;
    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef RAM_RW_CHECK_EN
    logic [DATA_W:0] pipe_in, pipe_out;
    logic            mis;
    logic            err_q;
    logic [ADDR_W:0] err_cnt_q;

    // Each READ cycle launches its expectation; it emerges exactly when the
    // RAM returns that address's data.
    assign pipe_in = {state_q == ST_READ, pat(addr_q)};

    rd_lat_pipe #(
        .W      (DATA_W + 1),
        .STAGES (RD_LAT)
    ) u_rd_lat_pipe (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .d_i    (pipe_in),
        .q_o    (pipe_out)
    );

    assign mis = pipe_out[DATA_W] && (ram_rdata != pipe_out[DATA_W-1:0]);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (mis) begin
            err_q <= 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^ram_rdata;
    assign err          = 1'b0;
    assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_ram_rw_ctrl.sv
module tb_ram_rw_ctrl;

    localparam int DEPTH = 32;
`ifdef RAM_RW_CHECK_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0, start2 = 1'b0;
    logic flt = 1'b0;
    always #5 clk = ~clk;

    logic       en1, we1, busy1, done1, err1;
    logic [4:0] addr1;
    logic [7:0] wdata1, rdata1;
    logic [5:0] cnt1;
    logic       en2, we2, busy2, done2, err2;
    logic [4:0] addr2;
    logic [7:0] wdata2, rdata2, rdata2a;
    logic [5:0] cnt2;

    ram_rw_ctrl #(.ADDR_W(5), .DEPTH(DEPTH), .DATA_W(8), .RD_LAT(1)) u_dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start1),
        .ram_en(en1), .ram_we(we1), .ram_addr(addr1), .ram_wdata(wdata1),
        .ram_rdata(rdata1), .busy(busy1), .done(done1), .err(err1), .err_cnt(cnt1)
    );

    ram_rw_ctrl #(.ADDR_W(5), .DEPTH(DEPTH), .DATA_W(8), .RD_LAT(2)) u_dut2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start2),
        .ram_en(en2), .ram_we(we2), .ram_addr(addr2), .ram_wdata(wdata2),
        .ram_rdata(rdata2), .busy(busy2), .done(done2), .err(err2), .err_cnt(cnt2)
    );

    // RAM models: unregistered-output BRAM (1 clock) and output-registered (2 clocks).
    // flt flips bit0 of whatever is read from address 5.
    logic [7:0] mem1 [0:31];
    logic [7:0] mem2 [0:31];
    always @(posedge clk) begin
        if (en1 && we1) mem1[addr1] <= wdata1;
        if (en1 && !we1) rdata1 <= mem1[addr1] ^ ((flt && addr1 == 5'd5) ? 8'h01 : 8'h00);
        if (en2 && we2) mem2[addr2] <= wdata2;
        if (en2 && !we2) rdata2a <= mem2[addr2] ^ ((flt && addr2 == 5'd5) ? 8'h01 : 8'h00);
        rdata2 <= rdata2a;
    end

    int sel = 0;
    logic       m_en, m_we, m_busy, m_done, m_err;
    logic [4:0] m_addr;
    logic [7:0] m_wdata;
    logic [5:0] m_cnt;
    assign m_en    = (sel == 0) ? en1    : en2;
    assign m_we    = (sel == 0) ? we1    : we2;
    assign m_busy  = (sel == 0) ? busy1  : busy2;
    assign m_done  = (sel == 0) ? done1  : done2;
    assign m_err   = (sel == 0) ? err1   : err2;
    assign m_addr  = (sel == 0) ? addr1  : addr2;
    assign m_wdata = (sel == 0) ? wdata1 : wdata2;
    assign m_cnt   = (sel == 0) ? cnt1   : cnt2;

    logic [23:0] outs1, outs2;
    assign outs1 = {en1, we1, addr1, wdata1, busy1, done1, err1, cnt1};
    assign outs2 = {en2, we2, addr2, wdata2, busy2, done2, err2, cnt2};

    int checks = 0, fails = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 0) start1 = v;
        else          start2 = v;
    endtask

    // Called at a negedge; start is sampled on the next posedge (edge 1).
    // n counts negedges after that edge, so n = 1 is the first WRITE cycle.
    task automatic run_pass(input string nm, input int lat, input int restart_at,
                            input int exp_rise, input int exp_cnt, input bit chk_clr);
        int done_n = 0, ndone = 0, rise = 0, wr_bad = 0, rd_bad = 0, busy_bad = 0;
        logic [7:0] ew;
        set_start(1'b1);
        @(negedge clk);
        for (int n = 1; n <= 200; n++) begin
            set_start(n == restart_at);
            if (chk_clr && n == 1) chk({nm, "_err_clr"}, {m_err, m_cnt}, 0);
            ew = 8'(255 - (n - 1));
            if (n <= DEPTH) begin
                if ({m_en, m_we, m_addr, m_wdata} !== {1'b1, 1'b1, 5'(n - 1), ew}) wr_bad++;
            end else if (n <= 2 * DEPTH) begin
                if ({m_en, m_we, m_addr, m_wdata} !== {1'b1, 1'b0, 5'(n - 1 - DEPTH), 8'h00}) rd_bad++;
            end else if ({m_en, m_we, m_addr, m_wdata} !== 15'h0) rd_bad++;
            if (!m_busy) busy_bad++;
            if (m_err && rise == 0) rise = n;
            if (m_done) begin
                ndone++;
                done_n = n;
                break;
            end
            @(negedge clk);
        end
        set_start(1'b0);
        chk({nm, "_done_lat"}, done_n, 2 * DEPTH + lat + 1);
        chk({nm, "_writes"}, wr_bad, 0);
        chk({nm, "_reads"}, rd_bad, 0);
        chk({nm, "_busy"}, busy_bad, 0);
        chk({nm, "_err_rise"}, rise, exp_rise);
        chk({nm, "_err"}, m_err, (exp_cnt != 0));
        chk({nm, "_err_cnt"}, m_cnt, exp_cnt);
        // One clock later: back in IDLE, done was a single pulse.
        @(negedge clk);
        chk({nm, "_post"}, {m_done, m_busy, m_en}, 0);
    endtask

    initial begin
        int bad;
        // 1: reset and idle
        #6;
        chk("rst_outs", {outs1, outs2}, 0);
        #1 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({outs1, outs2} !== 48'h0) bad++;
        end
        chk("idle_outs", bad, 0);

        // 2: clean pass, RD_LAT=1
        sel = 0;
        run_pass("clean1", 1, 0, 0, 0, 1'b0);

        // 3 + 4: fault at addr 5, with an ignored start at clock 10.
        // Addr 5 is presented at n=38, data compared RD_LAT edges later,
        // so err is first visible at n = DEPTH + 5 + RD_LAT + 2.
        flt = 1'b1;
        run_pass("fault1", 1, 10, CHK_ON ? DEPTH + 5 + 1 + 2 : 0, CHK_ON ? 1 : 0, 1'b0);
        flt = 1'b0;
        // Start one clock after done: new pass, err cleared on its start edge.
        run_pass("again1", 1, 0, 0, 0, 1'b1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (en1 || busy1 || done1) bad++;
        end
        chk("no_restart", bad, 0);

        // 5: reset mid-write at addr 12
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        bad = 1;
        for (int i = 0; i < 40; i++) begin
            if (en1 && we1 && addr1 == 5'd12) begin
                bad = 0;
                break;
            end
            @(negedge clk);
        end
        chk("reach_addr12", bad, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid", outs1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done1 || en1 || busy1) bad++;
        end
        chk("rst_no_done", bad, 0);
        run_pass("after_rst", 1, 0, 0, 0, 1'b0);

        // 6: RD_LAT=2 with registered-output RAM
        sel = 1;
        run_pass("clean2", 2, 0, 0, 0, 1'b0);
        flt = 1'b1;
        run_pass("fault2", 2, 0, CHK_ON ? DEPTH + 5 + 2 + 2 : 0, CHK_ON ? 1 : 0, 1'b0);
        flt = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
